div_share_sched: RTL and testbench

- Sequencer and arbiter that shares one unsigned long slow divider between two requesters (A = core execute stage, B = coprocessor/debug path).
- Accepts RISC-V DIV/DIVU/REM/REMU operations and arbitrates round-robin.
- Converts signed operands to magnitudes, starts the divider, and waits for its done pulse. It then applies sign fix-up and the RISC-V special cases, and returns the result to the winning requester.
- Sits between the requesters and the divider instance in the mul_div subsystem.

---
 rtl/div_share_sched.sv | 229 ++++++++++++++++++++++
 tb/tb_div_share_sched.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_share_sched.sv
// Round-robin sequencer that shares one unsigned multi-cycle divider between two
// requesters, applying RISC-V DIV/DIVU/REM/REMU sign handling and special cases.
module div_share_sched #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_a,
    input  logic [1:0]            op_a,
    input  logic [DATA_WIDTH-1:0] dividend_a,
    input  logic [DATA_WIDTH-1:0] divisor_a,
    output logic                  ack_a,
    output logic                  done_a,
    output logic [DATA_WIDTH-1:0] result_a,
    input  logic                  req_b,
    input  logic [1:0]            op_b,
    input  logic [DATA_WIDTH-1:0] dividend_b,
    input  logic [DATA_WIDTH-1:0] divisor_b,
    output logic                  ack_b,
    output logic                  done_b,
    output logic [DATA_WIDTH-1:0] result_b,
    output logic                  busy,
    output logic                  timeout_err,
    output logic                  div_enable_out,
    output logic [DATA_WIDTH-1:0] div_numerator,
    output logic [DATA_WIDTH-1:0] div_denominator,
    input  logic                  div_done,
    input  logic [DATA_WIDTH-1:0] div_quotient,
    input  logic [DATA_WIDTH-1:0] div_remainder
);

    localparam int unsigned DW    = DATA_WIDTH;
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [DW-1:0] MIN_NEG = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [4:0] {
        S_IDLE  = 5'b00001,
        S_ISSUE = 5'b00010,
        S_WAIT  = 5'b00100,
        S_FIXUP = 5'b01000,
        S_DONE  = 5'b10000
    } state_t;

    state_t             state_q, state_d;
    logic               prio_b_q, prio_b_d;
    logic               owner_q, owner_d;
    logic               rem_op_q, rem_op_d;
    logic               sgn_op_q, sgn_op_d;
    logic               neg_quo_q, neg_quo_d;
    logic               neg_rem_q, neg_rem_d;
    logic               special_q, special_d;
    logic [DW-1:0]      spec_q, spec_d;
    logic [DW-1:0]      num_q, num_d;
    logic [DW-1:0]      den_q, den_d;
    logic [DW-1:0]      quo_q, quo_d;
    logic [DW-1:0]      rem_q, rem_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ack_a_q, ack_a_d, ack_b_q, ack_b_d;
    logic               done_a_q, done_a_d, done_b_q, done_b_d;
    logic [DW-1:0]      res_a_q, res_a_d, res_b_q, res_b_d;
    logic               busy_q, busy_d;
    logic               tmo_q, tmo_d;
    logic               en_q, en_d;

    logic               gnt_a_c, gnt_b_c;
    logic [1:0]         cap_op_c;
    logic [DW-1:0]      cap_x_c, cap_y_c;
    logic               cap_sgn_c, sn_c, sd_c, div0_c, ovf_c;
    logic [DW-1:0]      sel_c, fix_c;
    logic               neg_c;

    // Round-robin winner and capture-side operand decode
    assign gnt_a_c   = req_a & (~req_b | ~prio_b_q);
    assign gnt_b_c   = req_b & (~req_a | prio_b_q);
    assign cap_op_c  = gnt_b_c ? op_b : op_a;
    assign cap_x_c   = gnt_b_c ? dividend_b : dividend_a;
    assign cap_y_c   = gnt_b_c ? divisor_b : divisor_a;
    assign cap_sgn_c = ~cap_op_c[0];
    assign sn_c      = cap_sgn_c & cap_x_c[DW-1];
    assign sd_c      = cap_sgn_c & cap_y_c[DW-1];
    assign div0_c    = (cap_y_c == '0);
    assign ovf_c     = cap_sgn_c & (cap_x_c == MIN_NEG) & (cap_y_c == '1);

    // Sign fix-up of the divider magnitude result
    assign sel_c = rem_op_q ? rem_q : quo_q;
    assign neg_c = sgn_op_q & (rem_op_q ? neg_rem_q : neg_quo_q);
    assign fix_c = special_q ? spec_q : (neg_c ? (~sel_c + DW'(1)) : sel_c);

    always_comb begin
        state_d   = state_q;
        prio_b_d  = prio_b_q;
        owner_d   = owner_q;
        rem_op_d  = rem_op_q;
        sgn_op_d  = sgn_op_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        special_d = special_q;
        spec_d    = spec_q;
        num_d     = num_q;
        den_d     = den_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        res_a_d   = res_a_q;
        res_b_d   = res_b_q;
        tmo_d     = tmo_q;
        ack_a_d   = 1'b0;
        ack_b_d   = 1'b0;
        done_a_d  = 1'b0;
        done_b_d  = 1'b0;
        en_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (gnt_a_c || gnt_b_c) begin
                    owner_d   = gnt_b_c;
                    prio_b_d  = gnt_a_c;
                    ack_a_d   = gnt_a_c;
                    ack_b_d   = gnt_b_c;
                    rem_op_d  = cap_op_c[1];
                    sgn_op_d  = cap_sgn_c;
                    neg_quo_d = cap_x_c[DW-1] ^ cap_y_c[DW-1];
                    neg_rem_d = cap_x_c[DW-1];
                    num_d     = sn_c ? (~cap_x_c + DW'(1)) : cap_x_c;
                    den_d     = sd_c ? (~cap_y_c + DW'(1)) : cap_y_c;
                    special_d = div0_c | ovf_c;
                    spec_d    = div0_c ? (cap_op_c[1] ? cap_x_c : '1)
                                       : (cap_op_c[1] ? '0 : MIN_NEG);
                    en_d      = ~(div0_c | ovf_c);
                    tmo_d     = 1'b0;
                    cnt_d     = '0;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: state_d = special_q ? S_FIXUP : S_WAIT;
            S_WAIT: begin
                if (div_done) begin
                    quo_d   = div_quotient;
                    rem_d   = div_remainder;
                    state_d = S_FIXUP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    quo_d   = '0;
                    rem_d   = '0;
                    tmo_d   = 1'b1;
                    state_d = S_FIXUP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_FIXUP: begin
                if (owner_q) res_b_d = fix_c;
                else         res_a_d = fix_c;
                state_d = S_DONE;
            end
            S_DONE: begin
                done_a_d = ~owner_q;
                done_b_d = owner_q;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            prio_b_q  <= 1'b0;
            owner_q   <= 1'b0;
            rem_op_q  <= 1'b0;
            sgn_op_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            special_q <= 1'b0;
            spec_q    <= '0;
            num_q     <= '0;
            den_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            ack_a_q   <= 1'b0;
            ack_b_q   <= 1'b0;
            done_a_q  <= 1'b0;
            done_b_q  <= 1'b0;
            res_a_q   <= '0;
            res_b_q   <= '0;
            busy_q    <= 1'b0;
            tmo_q     <= 1'b0;
            en_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            prio_b_q  <= prio_b_d;
            owner_q   <= owner_d;
            rem_op_q  <= rem_op_d;
            sgn_op_q  <= sgn_op_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            special_q <= special_d;
            spec_q    <= spec_d;
            num_q     <= num_d;
            den_q     <= den_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            ack_a_q   <= ack_a_d;
            ack_b_q   <= ack_b_d;
            done_a_q  <= done_a_d;
            done_b_q  <= done_b_d;
            res_a_q   <= res_a_d;
            res_b_q   <= res_b_d;
            busy_q    <= busy_d;
            tmo_q     <= tmo_d;
            en_q      <= en_d;
        end
    end

    assign ack_a           = ack_a_q;
    assign ack_b           = ack_b_q;
    assign done_a          = done_a_q;
    assign done_b          = done_b_q;
    assign result_a        = res_a_q;
    assign result_b        = res_b_q;
    assign busy            = busy_q;
    assign timeout_err     = tmo_q;
    assign div_enable_out  = en_q;
    assign div_numerator   = num_q;
    assign div_denominator = den_q;

endmodule

// File: tb/tb_div_share_sched.sv
// Randomized scoreboard bench for div_share_sched with a behavioural divider stub
// and an arithmetic reference model of the RISC-V divide rules and arbitration.
module tb_div_share_sched;

    localparam int TMO = 64;
    localparam logic [31:0] MIN_NEG = 32'h8000_0000;
    localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

    logic clk;
    logic reset_n;
    logic req_a, req_b, ack_a, ack_b, done_a, done_b;
    logic [1:0] op_a, op_b;
    logic [31:0] dividend_a, divisor_a, dividend_b, divisor_b, result_a, result_b;
    logic busy, timeout_err, div_enable_out, div_done;
    logic [31:0] div_numerator, div_denominator, div_quotient, div_remainder;

    int checks = 0;
    int errors = 0;
    int stub_lat = 3;
    bit stub_never = 0;
    bit stub_pulse = 0;

    typedef struct {
        bit          owner;
        logic [31:0] res;
        bit          tmo;
        int          lat;
        int          starts;
    } exp_t;
    exp_t exp_q[$];

    div_share_sched #(.DATA_WIDTH(32), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_a(req_a), .op_a(op_a), .dividend_a(dividend_a), .divisor_a(divisor_a),
        .ack_a(ack_a), .done_a(done_a), .result_a(result_a),
        .req_b(req_b), .op_b(op_b), .dividend_b(dividend_b), .divisor_b(divisor_b),
        .ack_b(ack_b), .done_b(done_b), .result_b(result_b),
        .busy(busy), .timeout_err(timeout_err), .div_enable_out(div_enable_out),
        .div_numerator(div_numerator), .div_denominator(div_denominator),
        .div_done(div_done), .div_quotient(div_quotient), .div_remainder(div_remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // RISC-V divide semantics written directly from the ISA rules
    function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int sa, sb;
        sa = int'(a);
        sb = int'(b);
        case (op)
            DIV:  if (b == 0) return 32'hFFFF_FFFF;
                  else if (a == MIN_NEG && b == 32'hFFFF_FFFF) return MIN_NEG;
                  else return 32'(sa / sb);
            DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            REM:  if (b == 0) return a;
                  else if (a == MIN_NEG && b == 32'hFFFF_FFFF) return 32'h0;
                  else return 32'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit uses_divider(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
        return (b != 0) && !(op[0] == 1'b0 && a == MIN_NEG && b == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] rnd_opnd(input bit is_divisor);
        case ($urandom_range(0, 5))
            0: return is_divisor ? 32'h0 : MIN_NEG;
            1: return is_divisor ? 32'hFFFF_FFFF : 32'h0;
            2: return 32'($urandom_range(0, 20));
            3: return -32'($urandom_range(1, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    // Divider stub: answers stub_lat cycles after the start pulse
    initial begin
        int cnt;
        bit bsy;
        logic [31:0] n, d;
        cnt = 0; bsy = 0; n = 0; d = 0;
        div_done = 0; div_quotient = 0; div_remainder = 0;
        forever begin
            @(posedge clk); #1;
            div_done = 0;
            if (!reset_n) bsy = 0;
            else begin
                if (bsy) begin
                    cnt--;
                    if (cnt == 0) begin
                        bsy = 0;
                        d = div_denominator;
                        div_quotient = n / d;
                        div_remainder = n % d;
                        div_done = 1;
                    end
                end else if (stub_pulse) begin
                    div_done = 1;
                    div_quotient = 32'hDEAD_BEEF;
                    div_remainder = 32'h0000_1234;
                end
                if (div_enable_out && !stub_never) begin
                    bsy = 1;
                    cnt = stub_lat;
                    n = div_numerator;
                end
            end
        end
    end

    // Monitor / scoreboard
    logic p_req_a, p_req_b;
    logic [1:0] p_op_a, p_op_b;
    logic [31:0] p_x_a, p_y_a, p_x_b, p_y_b;
    bit last_b = 1;
    logic [31:0] m_res_a = 0, m_res_b = 0;
    int cyc = 0, ack_cyc = 0, en_cnt = 0;
    exp_t m_e;
    bit m_w;
    logic [1:0] m_o;
    logic [31:0] m_x, m_y;

    always @(negedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
            last_b = 1;
            m_res_a = 0;
            m_res_b = 0;
            en_cnt = 0;
        end else begin
            cyc++;
            if (ack_a || ack_b) begin
                chk("ack_both", {31'b0, ack_a & ack_b}, 32'h0);
                m_w = (p_req_a && p_req_b) ? !last_b : p_req_b;
                chk("ack_owner", {31'b0, ack_b}, {31'b0, m_w});
                last_b = m_w;
                m_o = m_w ? p_op_b : p_op_a;
                m_x = m_w ? p_x_b : p_x_a;
                m_y = m_w ? p_y_b : p_y_a;
                m_e.owner = m_w;
                m_e.starts = uses_divider(m_o, m_x, m_y) ? 1 : 0;
                if (m_e.starts == 1 && stub_never) begin
                    m_e.res = 0; m_e.tmo = 1; m_e.lat = TMO + 3;
                end else begin
                    m_e.res = ref_res(m_o, m_x, m_y);
                    m_e.tmo = 0;
                    m_e.lat = (m_e.starts == 1) ? 3 + stub_lat : 3;
                end
                exp_q.push_back(m_e);
                chk("tmo_clear_on_ack", {31'b0, timeout_err}, 32'h0);
                ack_cyc = cyc;
                en_cnt = 0;
            end
            if (div_enable_out) en_cnt++;
            if (done_a || done_b) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done done_a=%0b done_b=%0b expected no done", done_a, done_b);
                end else begin
                    m_e = exp_q.pop_front();
                    chk("done_owner", {31'b0, done_b}, {31'b0, m_e.owner});
                    chk("done_both", {31'b0, done_a & done_b}, 32'h0);
                    chk("result", m_e.owner ? result_b : result_a, m_e.res);
                    chk("timeout_err", {31'b0, timeout_err}, {31'b0, m_e.tmo});
                    chk("latency", cyc - ack_cyc, m_e.lat);
                    chk("start_pulses", en_cnt, m_e.starts);
                    chk("other_result", m_e.owner ? result_a : result_b,
                        m_e.owner ? m_res_a : m_res_b);
                    if (m_e.owner) m_res_b = m_e.res;
                    else           m_res_a = m_e.res;
                end
            end
        end
        p_req_a = req_a; p_req_b = req_b;
        p_op_a = op_a; p_op_b = op_b;
        p_x_a = dividend_a; p_y_a = divisor_a;
        p_x_b = dividend_b; p_y_b = divisor_b;
    end

    task automatic issue(input bit side, input logic [1:0] op, input logic [31:0] x,
                         input logic [31:0] y);
        int t;
        t = 0;
        if (side) begin req_b = 1; op_b = op; dividend_b = x; divisor_b = y; end
        else      begin req_a = 1; op_a = op; dividend_a = x; divisor_a = y; end
        do begin
            @(posedge clk); #1;
            t++;
        end while (!(side ? ack_b : ack_a) && t < 1000);
        if (t >= 1000) begin
            checks++; errors++;
            $display("FAIL ack_wait side=%0d no ack within %0d cycles", side, t);
        end
        if (side) req_b = 0;
        else      req_a = 0;
    endtask

    task automatic run_side(input bit side, input int n, input int maxgap);
        for (int i = 0; i < n; i++) begin
            logic [1:0] o;
            int g;
            o = 2'($urandom_range(0, 3));
            issue(side, o, rnd_opnd(0), rnd_opnd(1));
            g = $urandom_range(0, maxgap);
            repeat (g) begin @(posedge clk); #1; end
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((busy || exp_q.size() != 0) && t < 1000) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 1000) begin
            checks++; errors++;
            $display("FAIL wait_idle busy=%0b pending=%0d expected idle", busy, exp_q.size());
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 0;
        req_a = 0; req_b = 0; op_a = 0; op_b = 0;
        dividend_a = 0; divisor_a = 0; dividend_b = 0; divisor_b = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack_a", {31'b0, ack_a}, 0);
        chk("rst_ack_b", {31'b0, ack_b}, 0);
        chk("rst_done_a", {31'b0, done_a}, 0);
        chk("rst_done_b", {31'b0, done_b}, 0);
        chk("rst_result_a", result_a, 0);
        chk("rst_result_b", result_b, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_tmo", {31'b0, timeout_err}, 0);
        chk("rst_en", {31'b0, div_enable_out}, 0);
        chk("rst_num", div_numerator, 0);
        chk("rst_den", div_denominator, 0);
        reset_n = 1;
        @(posedge clk); #1;

        // Both requesters from reset, back-to-back: grants must alternate A,B,A,B
        stub_lat = 2;
        fork
            run_side(0, 4, 0);
            run_side(1, 4, 0);
        join
        wait_idle();

        stub_lat = 5;
        issue(0, DIVU, 32'd100, 32'd7);
        issue(0, REMU, 32'd100, 32'd7);
        issue(0, DIV, 32'hFFFF_FF9C, 32'd7);
        issue(0, REM, 32'hFFFF_FF9C, 32'd7);
        issue(0, REM, 32'd100, 32'hFFFF_FFF9);
        issue(0, DIV, 32'd5, 32'd0);
        issue(0, REMU, 32'd5, 32'd0);
        issue(0, DIV, MIN_NEG, 32'hFFFF_FFFF);
        issue(0, REM, MIN_NEG, 32'hFFFF_FFFF);
        wait_idle();

        for (int p = 0; p < 3; p++) begin
            stub_lat = (p == 0) ? 1 : (p == 1) ? 4 : 17;
            fork
                run_side(0, 25, 3);
                run_side(1, 25, 3);
            join
            wait_idle();
        end

        // Divider never answers: abort after TIMEOUT, sticky until next ack
        stub_never = 1;
        issue(0, DIVU, 32'd100, 32'd7);
        wait_idle();
        repeat (3) begin @(posedge clk); #1; end
        chk("tmo_sticky", {31'b0, timeout_err}, 1);
        stub_never = 0;
        stub_lat = 3;
        issue(1, DIV, 32'd50, 32'd7);
        wait_idle();

        // Stray div_done while idle must be ignored
        stub_pulse = 1;
        @(posedge clk); #1;
        stub_pulse = 0;
        repeat (3) begin @(posedge clk); #1; end
        chk("stray_done_busy", {31'b0, busy}, 0);

        // Reset while waiting on the divider
        stub_never = 1;
        issue(0, DIVU, 32'd1000, 32'd3);
        repeat (5) begin @(posedge clk); #1; end
        chk("pre_rst_busy", {31'b0, busy}, 1);
        #2 reset_n = 0;
        #1;
        chk("mid_rst_busy", {31'b0, busy}, 0);
        chk("mid_rst_done_a", {31'b0, done_a}, 0);
        chk("mid_rst_result_a", result_a, 0);
        @(posedge clk); #1;
        reset_n = 1;
        stub_never = 0;
        repeat (20) begin @(posedge clk); #1; end
        chk("post_rst_idle", {31'b0, busy}, 0);
        issue(1, DIVU, 32'd81, 32'd9);
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
